// File: rtl/jellyvl_synctimer_sync_rx.sv
// Sync-frame receiver: parses 10-byte command/timestamp/checksum frames from a
// byte stream and issues delay-compensated one-cycle correction pulses.
module jellyvl_synctimer_sync_rx #(
  parameter int TIMER_WIDTH   = 64,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [TIMER_WIDTH-1:0]   param_delay,
  input  logic                     rx_first,
  input  logic                     rx_last,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     correct_override,
  output logic [TIMER_WIDTH-1:0]   correct_time,
  output logic                     correct_valid,
  output logic [COUNTER_WIDTH-1:0] stat_good,
  output logic [COUNTER_WIDTH-1:0] stat_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [3:0]               r_idx;
  logic [3:0]               w_idx_next;
  logic [7:0]               r_cmd;
  logic [7:0]               r_sum;
  logic [7:0]               w_sum_next;
  logic [63:0]              r_ts;
  logic [2:0]               w_byte_sel;
  logic                     w_load;
  logic                     w_store;
  logic                     w_abort;
  logic                     w_error;
  logic                     w_good;
  logic [1:0]               w_err_cnt;
  logic [TIMER_WIDTH-1:0]   w_time;
  logic                     r_valid;
  logic                     r_override;
  logic [TIMER_WIDTH-1:0]   r_time;
  logic [COUNTER_WIDTH-1:0] r_good;
  logic [COUNTER_WIDTH-1:0] r_error;

  assign w_sum_next = r_sum + rx_data;
  assign w_byte_sel = 3'(r_idx - 4'd1);
  assign w_time     = r_ts[TIMER_WIDTH-1:0] + param_delay;
  assign w_err_cnt  = {1'b0, w_abort} + {1'b0, w_error};

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_store      = 1'b0;
    w_abort      = 1'b0;
    w_error      = 1'b0;
    w_good       = 1'b0;
    if (rx_valid) begin
      if (rx_first) begin
        // A new frame always wins; only an in-progress frame counts as aborted.
        w_abort = (r_state == ST_RECV);
        w_load  = 1'b1;
        if (rx_last) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
          w_idx_next   = 4'd0;
        end else begin
          w_state_next = ST_RECV;
          w_idx_next   = 4'd1;
        end
      end else if (r_state == ST_RECV) begin
        w_store = 1'b1;
        if (r_idx == 4'd9) begin
          w_idx_next = 4'd0;
          if (rx_last) begin
            w_state_next = ST_IDLE;
            if (w_sum_next == 8'h00 && (r_cmd == 8'h01 || r_cmd == 8'h02)) begin
              w_good = 1'b1;
            end else begin
              w_error = 1'b1;
            end
          end else begin
            w_error      = 1'b1;
            w_state_next = ST_DROP;
          end
        end else if (rx_last) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
          w_idx_next   = 4'd0;
        end else begin
          w_idx_next = r_idx + 4'd1;
        end
      end else if (r_state == ST_DROP && rx_last) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 4'd0;
      r_cmd      <= 8'h00;
      r_sum      <= 8'h00;
      r_ts       <= 64'd0;
      r_valid    <= 1'b0;
      r_override <= 1'b0;
      r_time     <= '0;
      r_good     <= '0;
      r_error    <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_load) begin
        r_cmd <= rx_data;
        r_sum <= rx_data;
      end else if (w_store) begin
        r_sum <= w_sum_next;
        if (r_idx != 4'd9) begin
          r_ts[{w_byte_sel, 3'b000} +: 8] <= rx_data;
        end
      end
      r_valid <= w_good;
      if (w_good) begin
        r_time     <= w_time;
        r_override <= (r_cmd == 8'h02);
      end
      r_good  <= r_good + COUNTER_WIDTH'(w_good);
      r_error <= r_error + COUNTER_WIDTH'(w_err_cnt);
    end
  end

  // Gating by reset lets a reset in the pulse cycle suppress that frame's pulse.
  assign correct_valid    = r_valid & ~reset;
  assign correct_override = r_override;
  assign correct_time     = r_time;
  assign stat_good        = r_good;
  assign stat_error       = r_error;

endmodule

// File: tb/tb_jellyvl_synctimer_sync_rx.sv
// Self-checking bench for jellyvl_synctimer_sync_rx: frame-level reference model,
// per-cycle output comparison, directed literal checks and randomized frames.
module tb_jellyvl_synctimer_sync_rx;

  localparam int TW = 64;
  localparam int CW = 16;

  logic          reset;
  logic          clk;
  logic [TW-1:0] param_delay;
  logic          rx_first;
  logic          rx_last;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          correct_override;
  logic [TW-1:0] correct_time;
  logic          correct_valid;
  logic [CW-1:0] stat_good;
  logic [CW-1:0] stat_error;

  jellyvl_synctimer_sync_rx #(.TIMER_WIDTH(TW), .COUNTER_WIDTH(CW)) dut (
    .reset            (reset),
    .clk              (clk),
    .param_delay      (param_delay),
    .rx_first         (rx_first),
    .rx_last          (rx_last),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .correct_override (correct_override),
    .correct_time     (correct_time),
    .correct_valid    (correct_valid),
    .stat_good        (stat_good),
    .stat_error       (stat_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bytes of the current frame and judges the
  // frame as a whole once it ends. Idle and drop behave identically here.
  logic [7:0]    m_q[$];
  bit            m_collect;
  bit            m_valid;
  logic [TW-1:0] m_time;
  bit            m_ovr;
  logic [CW-1:0] m_good;
  logic [CW-1:0] m_err;

  function automatic bit frame_ok(input logic [7:0] q[$]);
    logic [7:0] s;
    if (q.size() != 10) return 1'b0;
    s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return (s == 8'h00) && (q[0] == 8'h01 || q[0] == 8'h02);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_collect = 1'b0;
      m_valid   = 1'b0;
      m_time    = '0;
      m_ovr     = 1'b0;
      m_good    = '0;
      m_err     = '0;
    end else begin
      m_valid = 1'b0;
      if (rx_valid) begin
        if (rx_first) begin
          if (m_collect) m_err = m_err + 1'b1;
          m_q       = {rx_data};
          m_collect = 1'b1;
          if (rx_last) begin
            m_err     = m_err + 1'b1;
            m_collect = 1'b0;
          end
        end else if (m_collect) begin
          m_q.push_back(rx_data);
          if (rx_last) begin
            m_collect = 1'b0;
            if (frame_ok(m_q)) begin
              logic [63:0] ts;
              ts = '0;
              for (int i = 1; i <= 8; i++) ts = ts | (64'(m_q[i]) << (8 * (i - 1)));
              m_time  = ts[TW-1:0] + param_delay;
              m_ovr   = (m_q[0] == 8'h02);
              m_valid = 1'b1;
              m_good  = m_good + 1'b1;
            end else begin
              m_err = m_err + 1'b1;
            end
          end else if (m_q.size() == 10) begin
            m_err     = m_err + 1'b1;
            m_collect = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("valid", 64'(correct_valid), 64'(m_valid));
      if (m_valid) begin
        check("time", 64'(correct_time), 64'(m_time));
        check("override", 64'(correct_override), 64'(m_ovr));
      end
      check("stat_good", 64'(stat_good), 64'(m_good));
      check("stat_error", 64'(stat_error), 64'(m_err));
    end
  end

  // Frame under construction.
  logic [7:0] fq[$];

  task automatic make_frame(input logic [7:0] cmd, input logic [63:0] ts, input logic [7:0] adj);
    logic [7:0] s;
    fq = {cmd};
    s  = cmd;
    for (int i = 0; i < 8; i++) begin
      fq.push_back(ts[8*i +: 8]);
      s = s + ts[8*i +: 8];
    end
    fq.push_back(8'h00 - s + adj);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit first, input bit last, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    for (int g = 0; g < gaps; g++) begin
      rx_valid = 1'b0;
      rx_first = 1'($urandom);
      rx_last  = 1'($urandom);
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_first = first;
    rx_last  = last;
    rx_data  = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_first = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic send_fq(input bit with_last, input int gap_max);
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i], i == 0, with_last && (i == fq.size() - 1), gap_max);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int kind;
    reset       = 1'b1;
    param_delay = '0;
    rx_first    = 1'b0;
    rx_last     = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    @(posedge clk); #1;
    do_reset(3);
    @(negedge clk);
    check("rst_valid", 64'(correct_valid), 64'd0);
    check("rst_override", 64'(correct_override), 64'd0);
    check("rst_time", 64'(correct_time), 64'd0);
    check("rst_good", 64'(stat_good), 64'd0);
    check("rst_error", 64'(stat_error), 64'd0);

    // Correction frame with delay compensation.
    param_delay = 64'd100;
    make_frame(8'h01, 64'h0000_0001_0000_0000, 8'h00);
    send_fq(1'b1, 0);
    @(negedge clk);
    check("f1_valid", 64'(correct_valid), 64'd1);
    check("f1_time", 64'(correct_time), 64'h0000_0001_0000_0064);
    check("f1_override", 64'(correct_override), 64'd0);
    check("f1_good", 64'(stat_good), 64'd1);

    // Set frame whose compensated time wraps.
    param_delay = 64'h20;
    make_frame(8'h02, 64'hFFFF_FFFF_FFFF_FFF0, 8'h00);
    send_fq(1'b1, 0);
    @(negedge clk);
    check("f2_time", 64'(correct_time), 64'h10);
    check("f2_override", 64'(correct_override), 64'd1);
    check("f2_good", 64'(stat_good), 64'd2);

    // Checksum off by one.
    make_frame(8'h01, 64'h55, 8'h01);
    send_fq(1'b1, 0);
    @(negedge clk);
    check("csum_valid", 64'(correct_valid), 64'd0);
    check("csum_error", 64'(stat_error), 64'd1);
    check("csum_good", 64'(stat_good), 64'd2);

    // Frame aborted by rx_first at B5, then a good frame.
    make_frame(8'h01, 64'h77, 8'h00);
    fq = fq[0:4];
    send_fq(1'b0, 0);
    make_frame(8'h01, 64'h1234, 8'h00);
    send_fq(1'b1, 0);
    @(negedge clk);
    check("abort_valid", 64'(correct_valid), 64'd1);
    check("abort_time", 64'(correct_time), 64'h1254);
    check("abort_error", 64'(stat_error), 64'd2);

    // 12-byte frame followed immediately by a good frame, then a 7-byte frame.
    make_frame(8'h01, 64'h99, 8'h00);
    fq.push_back(8'hA5);
    fq.push_back(8'h5A);
    send_fq(1'b1, 0);
    make_frame(8'h02, 64'hABCD, 8'h00);
    send_fq(1'b1, 0);
    @(negedge clk);
    check("long_valid", 64'(correct_valid), 64'd1);
    check("long_time", 64'(correct_time), 64'hABED);
    check("long_error", 64'(stat_error), 64'd3);
    check("long_good", 64'(stat_good), 64'd4);
    make_frame(8'h01, 64'h1, 8'h00);
    fq = fq[0:6];
    send_fq(1'b1, 0);
    @(negedge clk);
    check("short_error", 64'(stat_error), 64'd4);

    // Two good frames with random gaps, then reset inside a third.
    param_delay = 64'd5;
    make_frame(8'h01, 64'd1000, 8'h00);
    send_fq(1'b1, 3);
    make_frame(8'h02, 64'd2000, 8'h00);
    send_fq(1'b1, 3);
    @(negedge clk);
    check("gap_time", 64'(correct_time), 64'd2005);
    check("gap_good", 64'(stat_good), 64'd6);
    make_frame(8'h01, 64'd3000, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(fq[i], i == 0, 1'b0, 2);
    do_reset(1);
    for (int i = 5; i < 10; i++) send_byte(fq[i], 1'b0, i == 9, 2);
    @(negedge clk);
    check("mid_rst_valid", 64'(correct_valid), 64'd0);
    check("mid_rst_good", 64'(stat_good), 64'd0);
    check("mid_rst_error", 64'(stat_error), 64'd0);

    // Reset in the pulse cycle suppresses the pulse.
    make_frame(8'h01, 64'd42, 8'h00);
    send_fq(1'b1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("pulse_rst_valid", 64'(correct_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("pulse_rst_good", 64'(stat_good), 64'd0);

    // Randomized traffic mix.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) param_delay = {$urandom, $urandom};
      kind = int'($urandom_range(0, 9));
      case (kind)
        4:       make_frame(8'h01, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
        5:       make_frame(8'($urandom_range(3, 255)), {$urandom, $urandom}, 8'h00);
        default: make_frame(8'($urandom_range(1, 2)), {$urandom, $urandom}, 8'h00);
      endcase
      if (kind == 6) begin
        len = int'($urandom_range(1, 9));
        fq  = fq[0:len-1];
      end else if (kind == 7) begin
        len = int'($urandom_range(1, 3));
        for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
      end else if (kind == 8) begin
        len = int'($urandom_range(1, 10));
        fq  = fq[0:len-1];
      end
      if (kind == 9) begin
        send_byte(8'($urandom), 1'b0, 1'($urandom), 2);
      end else begin
        send_fq(kind != 8, (n % 3 == 0) ? 0 : 2);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jellyvl_synctimer_sync_rx.md
# jellyvl_synctimer_sync_rx

Parses sync frames arriving as a byte stream from the link receiver and produces the `correct_time` / `correct_valid` / `correct_override` inputs of the synctimer core. Each frame is validated for framing and checksum. Good frames are compensated by a programmable link delay and issued as one-cycle correction pulses. Good-frame and error counters are provided for status readout.

## Interface
- `TIMER_WIDTH`, default 64: width of the timer. Must be 1..64.
- `COUNTER_WIDTH`, default 16: width of the status counters.
- `reset`, in, 1: synchronous, active-high.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `param_delay`, in, `TIMER_WIDTH`: link delay compensation, added modulo 2^`TIMER_WIDTH`. Sampled on the cycle the last byte is accepted.
- `rx_first`, in, 1: marks the first byte of a frame.
- `rx_last`, in, 1: marks the last byte of a frame.
- `rx_data`, in, 8: frame byte.
- `rx_valid`, in, 1: byte strobe. There is no ready; the block always accepts.
- `correct_override`, out, 1: 1 for a set frame, 0 for a correction frame. Meaningful only while `correct_valid` is 1.
- `correct_time`, out, `TIMER_WIDTH`: compensated time.
- `correct_valid`, out, 1: one-cycle pulse per good frame.
- `stat_good`, out, `COUNTER_WIDTH`: good-frame count. Wraps.
- `stat_error`, out, `COUNTER_WIDTH`: errored-frame count. Wraps.

## Operation
- Frame layout is exactly 10 bytes:
  - B0: command. 0x01 = correct, 0x02 = set/override.
  - B1..B8: timestamp, little-endian. Bits above `TIMER_WIDTH` are ignored.
  - B9: checksum. The 8-bit sum of B0..B9 must equal 0x00.
- States: IDLE, RECV, DROP. Byte index `idx` runs 0..9. The running sum is 8 bits.
- IDLE:
  - A byte with `rx_valid` & `rx_first` loads B0, sets `idx`=1 and goes to RECV.
  - If that byte also has `rx_last`, the frame is errored: count it and stay in IDLE.
  - A valid byte without `rx_first` is ignored. It is not counted.
- RECV, on each valid byte:
  - `rx_first` with `idx`≠0: abort the current frame (count one error) and restart using this byte as B0. This applies to the new byte whether it arrives in IDLE or RECV.
  - `rx_last` with `idx`<9: error, go to IDLE.
  - `idx`=9 with `rx_last`: the frame is complete. It is good if the checksum passes and the command is 0x01 or 0x02; otherwise it is an error. Go to IDLE.
  - `idx`=9 without `rx_last`: error, go to DROP.
- DROP: discard bytes until `rx_last`, then go to IDLE. A byte with `rx_first` starts a new frame as in IDLE; no additional error is counted.
- Good frame outputs:
  - `correct_time` = timestamp + `param_delay`.
  - `correct_override` = (command == 0x02).
  - `correct_valid` = 1 for exactly one cycle.
  - `stat_good` += 1.
- Each errored frame increments `stat_error` by exactly 1.
- `correct_time` and `correct_override` hold their value between pulses.

## Timing
- Reset values: state IDLE, `idx` 0, `correct_valid` 0, `correct_override` 0, `correct_time` 0, `stat_good` 0, `stat_error` 0.
- Latency: `correct_valid` is asserted on the cycle after B9 is accepted. Counters update on that same cycle.
- Back-to-back frames may have zero idle cycles between them. B0 of frame N+1 may arrive on the cycle `correct_valid` of frame N is high.
- `rx_valid` may deassert at any point mid-frame. The state holds with no timeout.
- When `rx_valid`=0, all `rx_*` inputs are ignored.
- Reset mid-frame discards the partial frame without counting it. Reset on the cycle after B9 suppresses that frame's pulse.
- The addition wraps modulo 2^`TIMER_WIDTH`. No saturation.

## Test plan
- Correct frame, command 0x01, timestamp 0x0000_0001_0000_0000, `param_delay`=100, valid checksum, no gaps. Required: `correct_valid` pulse one cycle after B9, `correct_time`=0x0000_0001_0000_0064, `correct_override`=0, `stat_good`=1.
- Set frame, command 0x02, timestamp 0xFFFF_FFFF_FFFF_FFF0, `param_delay`=0x20. Required: `correct_time`=0x10 (wrapped), `correct_override`=1.
- Good frame with B9 incremented by 1. Required: no pulse, `stat_error`=1, `stat_good` unchanged.
- `rx_first` reasserted at B5, followed by a complete good frame. Required: `stat_error`=1, one pulse carrying the second frame's time.
- A 12-byte frame with `rx_last` on byte 11, followed immediately by a good frame. Required: `stat_error`=1, the good frame is received normally. Also cover a 7-byte frame: `stat_error` +1.
- Two good frames back to back, with random `rx_valid` gaps inside them. Required: two pulses carrying correct times, `stat_good`=2. Apply reset between B4 and B5 of a third frame. Required: no pulse, all counters 0.
